uart_rx_frame: RTL



---
 rtl/uart_rx_frame.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_frame.sv
// 16x-oversampled UART receiver with 2-of-3 majority bit sampling and framing checks.
// Define UART_RX_PARITY_EN to build the 8E1 variant with an even-parity check.
`timescale 1ns/1ps

module uart_rx_frame #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200,
    parameter int DIV    = CLK_HZ / (BAUD * 16)
) (
    input  logic       clk,
    input  logic       rst_l,
    input  logic       rxd,
    output logic [7:0] rec_dataH,
    output logic       rec_readyH,
    output logic       frame_errH,
    output logic       par_errH,
    output logic       busyH
);

    localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_rxd_meta;
    logic            r_rxs;
    logic [TW-1:0]   r_tick_cnt;
    logic [3:0]      r_sc;
    logic            r_s7;
    logic            r_s8;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shift;
    logic [7:0]      r_data;
    logic            r_ready;
    logic            r_ferr;
    logic            w_tick;
    logic            w_mid;
    logic            w_bit_end;
    logic            w_maj;
    logic            w_sc_clr;
    logic            w_load;
    logic            w_ferr_nxt;
`ifdef UART_RX_PARITY_EN
    logic            r_par_bit;
    logic            r_perr;
    logic            w_perr_nxt;
`endif

    assign w_tick    = (r_tick_cnt == TW'(DIV - 1));
    assign w_mid     = w_tick && (r_sc == 4'd9);
    assign w_bit_end = w_tick && (r_sc == 4'd15);
    // r_s7/r_s8 hold the sc=7/8 samples; the live synchronized bit is the sc=9 sample.
    assign w_maj     = (r_s7 & r_s8) | (r_s7 & r_rxs) | (r_s8 & r_rxs);

    // NOTE: every sequential block uses non-blocking assignments so all flops
    // update from the same pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_rxd_meta <= 1'b1;
            r_rxs      <= 1'b1;
        end else begin
            r_rxd_meta <= rxd;
            r_rxs      <= r_rxd_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Tick and sample counters sit at zero in IDLE so a start edge begins a fresh bit phase.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_tick_cnt <= '0;
            r_sc       <= 4'd0;
            r_bit_cnt  <= 3'd0;
        end else begin
            if (r_state == S_IDLE || w_tick) begin
                r_tick_cnt <= '0;
            end else begin
                r_tick_cnt <= r_tick_cnt + TW'(1);
            end

            if (r_state == S_IDLE || w_sc_clr) begin
                r_sc <= 4'd0;
            end else if (w_tick) begin
                r_sc <= r_sc + 4'd1;
            end

            if (r_state == S_IDLE) begin
                r_bit_cnt <= 3'd0;
            end else if (r_state == S_DATA && w_bit_end) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_s7    <= 1'b1;
            r_s8    <= 1'b1;
            r_shift <= 8'h00;
        end else begin
            if (w_tick && r_sc == 4'd7) r_s7 <= r_rxs;
            if (w_tick && r_sc == 4'd8) r_s8 <= r_rxs;
            if (r_state == S_DATA && w_mid) r_shift <= {w_maj, r_shift[7:1]};
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_par_bit <= 1'b0;
            r_perr    <= 1'b0;
        end else begin
            if (r_state == S_PARITY && w_mid) r_par_bit <= w_maj;
            r_perr <= w_perr_nxt;
        end
    end
    assign par_errH = r_perr;
`else
    assign par_errH = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_data  <= 8'h00;
            r_ready <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            if (w_load) r_data <= r_shift;
            r_ready <= w_load;
            r_ferr  <= w_ferr_nxt;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_sc_clr    = 1'b0;
        w_load      = 1'b0;
        w_ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_perr_nxt  = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (!r_rxs) w_state_nxt = S_START;
            end
            S_START: begin
                if (w_mid && w_maj) begin
                    w_state_nxt = S_IDLE;
                end else if (w_bit_end) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end && r_bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                    w_state_nxt = S_PARITY;
`else
                    w_state_nxt = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) w_state_nxt = S_STOP;
            end
`endif
            // The stop decision is taken mid-bit so the next start edge can follow immediately.
            S_STOP: begin
                if (w_mid) begin
                    if (w_maj) begin
                        w_load      = 1'b1;
`ifdef UART_RX_PARITY_EN
                        w_perr_nxt  = ^{r_shift, r_par_bit};
`endif
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_ferr_nxt  = 1'b1;
                        w_sc_clr    = 1'b1;
                        w_state_nxt = S_WAIT_IDLE;
                    end
                end
            end
            // sc counts consecutive high ticks here; any low sample restarts the count.
            S_WAIT_IDLE: begin
                if (!r_rxs) begin
                    w_sc_clr = 1'b1;
                end else if (w_bit_end) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign rec_dataH  = r_data;
    assign rec_readyH = r_ready;
    assign frame_errH = r_ferr;
    assign busyH      = (r_state != S_IDLE);

endmodule
